lcd_write_engine: RTL and testbench

LCD_WRITE_ENGINE -- requirements
Module: lcd_write_engine

---
 rtl/lcd_write_engine.sv | 136 +++++++++++++
 tb/tb_lcd_write_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lcd_write_engine.sv
// HD44780-style write engine: one byte per handshake,
// strobed onto the panel bus then held for the command execution time.
module lcd_write_engine #(
  parameter int T_AS         = 2,
  parameter int T_EN         = 12,
  parameter int T_H          = 2,
  parameter int T_EXEC_SHORT = 2000,
  parameter int T_EXEC_LONG  = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int CW_MIN = $clog2(T_EXEC_LONG + 1);
  localparam int CW     = (CW_MIN > 18) ? CW_MIN : 18;

  localparam logic [CW-1:0] C_AS    = CW'(T_AS - 1);
  localparam logic [CW-1:0] C_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] C_H     = CW'(T_H - 1);
  localparam logic [CW-1:0] C_SHORT = CW'(T_EXEC_SHORT);
  localparam logic [CW-1:0] C_LONG  = CW'(T_EXEC_LONG);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [7:0]      r_data;
  logic            r_rs;
  logic            r_en;
  logic            w_lat;
  logic            w_long;
  logic            w_zero;

  // Clear Display / Return Home need the long execution wait
  assign w_long = ~r_rs
                & (r_data[7:2] == 6'd0)
                & (r_data[1:0] != 2'd0);
  assign w_zero = (r_cnt == '0);

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_lat     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (iStart) begin
          w_lat     = 1'b1;
          w_nxt     = SETUP;
          w_cnt_nxt = C_AS;
        end
      end
      SETUP: begin
        if (w_zero) begin
          w_nxt     = PULSE;
          w_cnt_nxt = C_EN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      PULSE: begin
        if (w_zero) begin
          w_nxt     = HOLD;
          w_cnt_nxt = C_H;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (w_zero) begin
          w_nxt     = EXEC;
          w_cnt_nxt = w_long ? C_LONG : C_SHORT;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      EXEC: begin
        if (w_zero) begin
          w_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DONE: begin
        if (!iStart) w_nxt = IDLE;
      end
      default: begin
        w_nxt     = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= 8'h00;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= (w_nxt == PULSE);
      if (w_lat) begin
        r_data <= iDATA;
        r_rs   <= iRS;
      end
    end
  end

  assign oDone    = (r_state == DONE);
  assign oBusy    = (r_state != IDLE);
  assign LCD_DATA = r_data;
  assign LCD_RS   = r_rs;
  assign LCD_EN   = r_en;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine with shortened timing:
// strobe placement, execution waits, handshake and reset behaviour.
module tb_lcd_write_engine;

  logic       iCLK;
  logic       iRST_N;
  logic [7:0] iDATA;
  logic       iRS;
  logic       iStart;
  logic       oDone;
  logic       oBusy;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  int checks;
  int errors;

  lcd_write_engine #(
    .T_AS(2),
    .T_EN(4),
    .T_H(2),
    .T_EXEC_SHORT(10),
    .T_EXEC_LONG(40)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iDATA(iDATA),
    .iRS(iRS),
    .iStart(iStart),
    .oDone(oDone),
    .oBusy(oBusy),
    .LCD_DATA(LCD_DATA),
    .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN),
    .LCD_RS(LCD_RS)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a clock edge with the engine idle.
  task automatic xfer(input string tag,
                      input logic rs,
                      input logic [7:0] d,
                      input int exp_done,
                      input int hold,
                      input bit pulse);
    int en_rise;
    int en_cnt;
    int done_at;
    int bad_data;
    int bad_rw;
    int bad_hold;
    iRS    = rs;
    iDATA  = d;
    iStart = 1'b1;
    @(posedge iCLK); #1;
    check({tag, " busy_acc"}, 32'(oBusy), 32'd1);
    check({tag, " data_acc"}, 32'(LCD_DATA), 32'(d));
    check({tag, " rs_acc"}, 32'(LCD_RS), 32'(rs));
    if (pulse) begin
      iStart = 1'b0;
      iRS    = ~rs;
    end
    en_rise  = -1;
    en_cnt   = 0;
    done_at  = -1;
    bad_data = 0;
    bad_rw   = 0;
    for (int cyc = 1; cyc <= exp_done + 10; cyc++) begin
      @(posedge iCLK); #1;
      if (pulse && cyc == 3) iDATA = 8'hFF;
      if (LCD_EN === 1'b1) begin
        en_cnt++;
        if (en_rise < 0) en_rise = cyc;
      end
      if (LCD_DATA !== d || LCD_RS !== rs) bad_data++;
      if (LCD_RW !== 1'b0) bad_rw++;
      if (oDone === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
    check({tag, " en_rise"}, 32'(en_rise), 32'd2);
    check({tag, " en_width"}, 32'(en_cnt), 32'd4);
    check({tag, " done_at"}, 32'(done_at), 32'(exp_done));
    check({tag, " data_hold"}, 32'(bad_data), 32'd0);
    check({tag, " rw_zero"}, 32'(bad_rw), 32'd0);
    bad_hold = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge iCLK); #1;
      if (oDone !== 1'b1 || LCD_EN !== 1'b0) bad_hold++;
    end
    if (hold > 0)
      check({tag, " done_held"}, 32'(bad_hold), 32'd0);
    iStart = 1'b0;
    check({tag, " busy_pre"}, 32'(oBusy), 32'd1);
    @(posedge iCLK); #1;
    check({tag, " done_fall"}, 32'(oDone), 32'd0);
    check({tag, " busy_fall"}, 32'(oBusy), 32'd0);
    check({tag, " data_keep"}, 32'(LCD_DATA), 32'(d));
    check({tag, " rs_keep"}, 32'(LCD_RS), 32'(rs));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    iRST_N = 1'b0;
    iStart = 1'b0;
    iRS    = 1'b0;
    iDATA  = 8'h00;
    #3;
    check("rst en", 32'(LCD_EN), 32'd0);
    check("rst data", 32'(LCD_DATA), 32'd0);
    check("rst rs", 32'(LCD_RS), 32'd0);
    check("rst rw", 32'(LCD_RW), 32'd0);
    check("rst done", 32'(oDone), 32'd0);
    check("rst busy", 32'(oBusy), 32'd0);
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    @(posedge iCLK); #1;

    xfer("d4F", 1'b1, 8'h4F, 19, 0, 1'b0);
    xfer("c01", 1'b0, 8'h01, 49, 0, 1'b0);
    xfer("c02", 1'b0, 8'h02, 49, 0, 1'b0);
    xfer("c38", 1'b0, 8'h38, 19, 0, 1'b0);
    xfer("c03", 1'b0, 8'h03, 49, 0, 1'b0);
    xfer("c00", 1'b0, 8'h00, 19, 0, 1'b0);
    xfer("c04", 1'b0, 8'h04, 19, 0, 1'b0);
    xfer("d01", 1'b1, 8'h01, 19, 0, 1'b0);
    xfer("hold", 1'b0, 8'h80, 19, 41, 1'b0);
    xfer("pulse", 1'b1, 8'h41, 19, 0, 1'b1);

    iRS    = 1'b1;
    iDATA  = 8'h5A;
    iStart = 1'b1;
    @(posedge iCLK); #1;
    repeat (3) @(posedge iCLK);
    #1;
    check("mid en", 32'(LCD_EN), 32'd1);
    #2;
    iRST_N = 1'b0;
    iStart = 1'b0;
    #1;
    check("arst en", 32'(LCD_EN), 32'd0);
    check("arst data", 32'(LCD_DATA), 32'd0);
    check("arst rs", 32'(LCD_RS), 32'd0);
    check("arst busy", 32'(oBusy), 32'd0);
    check("arst done", 32'(oDone), 32'd0);
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    xfer("post", 1'b1, 8'h55, 19, 0, 1'b0);

    xfer("b2b1", 1'b1, 8'hAA, 19, 0, 1'b0);
    xfer("b2b2", 1'b0, 8'h01, 49, 0, 1'b0);
    xfer("b2b3", 1'b1, 8'h02, 19, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
